// File: rtl/key_event_fsm.sv
`default_nettype none
// ============================================================================
// Module      : key_event_fsm
// Description : Turns the debounced, active-low KEY0 level into short,
//               double and long press events, presented through a one-entry
//               valid/ready output register with a sticky drop flag.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_fsm #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int DOUBLE_CYCLES = 15_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clean_key,
    output logic       key_level,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_overflow
);

    localparam int MAX_CYCLES = (LONG_CYCLES > DOUBLE_CYCLES) ? LONG_CYCLES : DOUBLE_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0] LONG_LAST   = TIMER_W'(LONG_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOUBLE_LAST = TIMER_W'(DOUBLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = {TIMER_W{1'b1}};

    localparam logic [2:0] S_IDLE           = 3'd0;
    localparam logic [2:0] S_PRESSED        = 3'd1;
    localparam logic [2:0] S_WAIT_SECOND    = 3'd2;
    localparam logic [2:0] S_SECOND_PRESSED = 3'd3;
    localparam logic [2:0] S_LONG_HELD      = 3'd4;

    localparam logic [1:0] EVT_SHORT  = 2'b01;
    localparam logic [1:0] EVT_DOUBLE = 2'b10;
    localparam logic [1:0] EVT_LONG   = 2'b11;

    logic [2:0]         state;
    logic [2:0]         state_next;
    logic [TIMER_W-1:0] timer;
    logic               key_prev;
    logic               key_prev_valid;
    logic               press;
    logic               release_det;
    logic               emit;
    logic [1:0]         emit_code;

    // key_prev is forced to "released" by reset, so the first cycle after
    // reset compares against a fake value; key_prev_valid masks that cycle so
    // a key held low through reset never looks like a fresh press.
    assign press       = key_prev_valid & key_prev & ~clean_key;
    assign release_det = ~key_prev & clean_key;

    // Input history: previous key sample, its validity, and the pressed level.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev       <= 1'b1;
            key_prev_valid <= 1'b0;
            key_level      <= 1'b0;
        end else begin
            key_prev       <= clean_key;
            key_prev_valid <= 1'b1;
            key_level      <= ~clean_key;
        end
    end

    // State register and timer; the timer restarts on every state change and
    // saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                timer <= '0;
            end else if ((state == S_PRESSED || state == S_WAIT_SECOND) && timer != TIMER_MAX) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Next-state logic; release beats the long timeout and a second press
    // beats the double-press timeout.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (press) state_next = S_PRESSED;
            end
            S_PRESSED: begin
                if (release_det)             state_next = S_WAIT_SECOND;
                else if (timer == LONG_LAST) state_next = S_LONG_HELD;
            end
            S_WAIT_SECOND: begin
                if (press)                     state_next = S_SECOND_PRESSED;
                else if (timer == DOUBLE_LAST) state_next = S_IDLE;
            end
            S_SECOND_PRESSED: begin
                if (release_det) state_next = S_IDLE;
            end
            S_LONG_HELD: begin
                if (release_det) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Event decode: which classified event, if any, this cycle produces.
    always_comb begin
        emit      = 1'b0;
        emit_code = 2'b00;
        unique case (state)
            S_PRESSED: begin
                if (!release_det && timer == LONG_LAST) begin
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                end
            end
            S_WAIT_SECOND: begin
                if (!press && timer == DOUBLE_LAST) begin
                    emit      = 1'b1;
                    emit_code = EVT_SHORT;
                end
            end
            S_SECOND_PRESSED: begin
                if (release_det) begin
                    emit      = 1'b1;
                    emit_code = EVT_DOUBLE;
                end
            end
            default: begin
                emit      = 1'b0;
                emit_code = 2'b00;
            end
        endcase
    end

    // One-entry output register: load when empty or draining, otherwise drop
    // the new event and remember that something was lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid    <= 1'b0;
            evt_code     <= 2'b00;
            evt_overflow <= 1'b0;
        end else if (emit && (!evt_valid || evt_ready)) begin
            evt_valid <= 1'b1;
            evt_code  <= emit_code;
        end else if (emit) begin
            evt_overflow <= 1'b1;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/key_event_fsm.md
# key_event_fsm

Classifies the debounced KEY0 level from the debounce stage into discrete user-command events: short press, double press, and long press. It sits directly downstream of the debouncer and upstream of the Neural-Engine control logic. Each classified event is held in a one-entry valid/ready output register until the controller accepts it.

## Interface
**Parameters**
- `LONG_CYCLES`, default 50_000_000: hold duration in `clk` cycles that makes a long press (1 s at 50 MHz).
- `DOUBLE_CYCLES`, default 15_000_000: maximum release-to-second-press gap in cycles for a double press (300 ms).
- Timer width is `$clog2(max(LONG_CYCLES, DOUBLE_CYCLES) + 1)` bits.

**Ports**
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `clean_key`, in, 1: debounced KEY0 level. Active-low: 0 means pressed. It is already synchronous to `clk`.
- `key_level`, out, 1: registered pressed indication, equal to `~clean_key` delayed one cycle.
- `evt_valid`, out, 1: an event is pending in the output register.
- `evt_code`, out, 2: event code. 2'b01 short, 2'b10 double, 2'b11 long. 2'b00 is never presented while valid.
- `evt_ready`, in, 1: the consumer accepts the event in any cycle where `evt_valid && evt_ready`.
- `evt_overflow`, out, 1: sticky flag. Set when an event is dropped. Cleared only by `rst`.

## Operation
**Edge detection**
- `key_prev` is registered `clean_key`. Reset value is 1 (released).
- press = `key_prev & ~clean_key`.
- release = `~key_prev & clean_key`.

**FSM states:** IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED, LONG_HELD.
- `timer` clears on every state entry and increments by 1 each cycle in PRESSED and WAIT_SECOND. It saturates and never wraps.
- **IDLE:** press → PRESSED.
- **PRESSED:**
  - `timer == LONG_CYCLES-1` with no release → emit LONG, go to LONG_HELD.
  - release before that → WAIT_SECOND.
  - If release and timeout occur in the same cycle, release wins.
- **WAIT_SECOND:**
  - press → SECOND_PRESSED.
  - `timer == DOUBLE_CYCLES-1` with no press → emit SHORT, go to IDLE.
  - If press and timeout occur in the same cycle, press wins.
- **SECOND_PRESSED:** release → emit DOUBLE, go to IDLE. There is no long detection on the second press; hold duration is ignored.
- **LONG_HELD:** release → IDLE. No event is emitted.

**Output register**
- Load on emit when `!evt_valid`, or when `evt_valid && evt_ready` in the same cycle. `evt_valid` then stays 1 and `evt_code` takes the new code.
- Emit while `evt_valid && !evt_ready`: the new event is discarded, the held event is unchanged, and `evt_overflow` is set to 1.
- `evt_valid && evt_ready` with no emit: `evt_valid` goes to 0 on the next edge.
- `evt_code` is held stable while `evt_valid && !evt_ready`.

**Reset**
- `rst` high at a clock edge forces:
  - state to IDLE
  - `timer` to 0
  - `key_prev` to 1
  - `key_level` to 0
  - `evt_valid` to 0
  - `evt_code` to 2'b00
  - `evt_overflow` to 0
- Reset takes priority over every other condition, including mid-press and a pending event; the pending event is lost.
- A key held low through reset release causes no press event. A press requires a new 1→0 transition.

## Timing
- A press is detected in the cycle `clean_key` first samples 0. The FSM is in PRESSED on the next edge with `timer = 0`.
- **LONG:** `evt_valid` rises on the edge after the cycle where `timer == LONG_CYCLES-1`. That is `LONG_CYCLES + 1` edges after the first sampled-low cycle.
- **SHORT:** `evt_valid` rises `DOUBLE_CYCLES + 1` edges after the release was detected.
- **DOUBLE:** `evt_valid` rises 1 edge after the second release is detected.
- **Handshake:**
  - No combinational path from `evt_ready` to `evt_valid`.
  - Accepting an event and loading the next one is possible every cycle.
- `key_level` lags `clean_key` by 1 cycle.

## Test plan
Benches run with `LONG_CYCLES = 20` and `DOUBLE_CYCLES = 10`; `evt_ready` is tied to 1 unless stated.
- **Reset values:** hold `rst` for 3 cycles with `clean_key = 0` throughout, then release `rst` → all outputs are 0, `evt_valid` stays 0 for 50 cycles, and no event occurs.
- **Short press:** drive `clean_key` low for 5 cycles, then high → one `evt_valid` pulse with `evt_code = 01` exactly 11 edges after the release was detected, and no other events.
- **Double press:** low 5, high 4, low 5, high → a single `evt_code = 10` one edge after the second release, and no SHORT emitted.
- **Long press:** hold low for 40 cycles → `evt_code = 11` exactly 21 edges after the first low sample. Release then produces no event, and the FSM returns to IDLE.
- **Boundaries:**
  - Release in exactly the cycle `timer == 19` in PRESSED → no LONG; a SHORT follows.
  - A second press in exactly the cycle `timer == 9` in WAIT_SECOND → DOUBLE.
- **Backpressure and reset:**
  - With `evt_ready = 0`, a SHORT is held with its code stable. A following LONG is dropped and `evt_overflow` becomes 1.
  - Raising `evt_ready` then gives one transfer of code `01`.
  - Asserting `rst` mid-long-press clears `evt_overflow` and `evt_valid`, and no event is produced.
